// File: rtl/vga_pmod_receiver.sv
// VGA PMOD capture: recovers sync timing, emits per-pixel x/y/RGB, locks to the nominal
// geometry and signs each locked frame with CRC-16-CCITT. Define VGA_RX_BLANK_CHECK_EN to flag blanking RGB.
module vga_pmod_receiver #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_pmod,
    output logic        o_pixel_valid,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic [1:0]  o_r,
    output logic [1:0]  o_g,
    output logic [1:0]  o_b,
    output logic        o_locked,
    output logic        o_frame_done,
    output logic [15:0] o_frame_crc,
    output logic [10:0] o_h_period,
    output logic [9:0]  o_v_lines,
    output logic        o_error
);

    localparam logic [10:0] HTotal  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0]  VTotal  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] HStart  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] HEnd    = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  VStart  = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  VEnd    = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] HSyncW  = 11'(H_SYNC);
    // Reset the input stage to "syncs deasserted" so the first real edge is not masked.
    localparam logic [7:0]  PmodIdle = {~SYNC_ACTIVE, 3'b000, ~SYNC_ACTIVE, 3'b000};

    typedef enum logic [1:0] {StAcquire, StMeasure, StLocked} state_e;

    state_e      state_q, state_d;
    logic [7:0]  pmod_q;
    logic        hs_prev_q, vs_edge_q;
    logic [10:0] hcnt_q, hpos, hsw_q, hsw_d, period;
    logic [9:0]  vcnt_q, vpos, lines;
    logic [15:0] crc_q, crc_d;
    logic        hs_act, vs_act, hs_edge, hs_fall, frame_start, active;
    logic        line_bad, width_bad, frame_bad, sat_hit, timing_bad, lock_fault;
    logic        err_d, done_d;
    logic [1:0]  r_s, g_s, b_s;
    logic [9:0]  x_d, y_d;

    assign hs_act      = (pmod_q[7] == SYNC_ACTIVE);
    assign vs_act      = (pmod_q[3] == SYNC_ACTIVE);
    assign hs_edge     = hs_act & ~hs_prev_q;
    assign hs_fall     = ~hs_act & hs_prev_q;
    assign frame_start = hs_edge & vs_act & ~vs_edge_q;
    assign r_s         = {pmod_q[0], pmod_q[4]};
    assign g_s         = {pmod_q[1], pmod_q[5]};
    assign b_s         = {pmod_q[2], pmod_q[6]};
    assign period      = (hcnt_q == 11'h7FF) ? 11'h7FF : hcnt_q + 11'd1;
    assign lines       = (vcnt_q == 10'h3FF) ? 10'h3FF : vcnt_q + 10'd1;

    function automatic logic [15:0] crc_step6(input logic [15:0] c, input logic [5:0] d);
        logic [15:0] c_n;
        logic        fb;
        c_n = c;
        for (int i = 5; i >= 0; i--) begin
            fb  = c_n[15] ^ d[i];
            c_n = {c_n[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c_n;
    endfunction

    // Position of the pixel currently in stage 1.
    always_comb begin
        hpos  = hs_edge ? 11'd0 : period;
        vpos  = vcnt_q;
        hsw_d = hsw_q;
        if (hs_edge) begin
            vpos  = frame_start ? 10'd0 : lines;
            hsw_d = 11'd1;
        end else if (hs_act && hsw_q != 11'h7FF) begin
            hsw_d = hsw_q + 11'd1;
        end
        active = (hpos >= HStart) && (hpos < HEnd) && (vpos >= VStart) && (vpos < VEnd);
        x_d    = active ? 10'(hpos - HStart) : 10'd0;
        y_d    = active ? (vpos - VStart) : 10'd0;
        crc_d  = crc_q;
        if (frame_start) begin
            crc_d = 16'hFFFF;
        end else if (active) begin
            crc_d = crc_step6(crc_q, {r_s, g_s, b_s});
        end
    end

    assign line_bad   = hs_edge & (period != HTotal);
    assign width_bad  = hs_fall & (hsw_q != HSyncW);
    assign frame_bad  = frame_start & (lines != VTotal);
    assign sat_hit    = ~hs_edge & (hcnt_q == 11'h7FE);
    assign timing_bad = line_bad | width_bad | frame_bad | sat_hit;

`ifdef VGA_RX_BLANK_CHECK_EN
    logic blank_bad;
    assign blank_bad  = ~active & ({r_s, g_s, b_s} != 6'd0);
    assign lock_fault = timing_bad | blank_bad;
`else
    assign lock_fault = timing_bad;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StAcquire: begin
                if (frame_start) state_d = StMeasure;
            end
            StMeasure: begin
                if (timing_bad) begin
                    state_d = StAcquire;
                end else if (frame_start) begin
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (lock_fault) begin
                    state_d = StAcquire;
                    err_d   = 1'b1;
                end else if (frame_start) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = StAcquire;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmod_q        <= PmodIdle;
            hs_prev_q     <= 1'b0;
            vs_edge_q     <= 1'b0;
            hcnt_q        <= 11'd0;
            vcnt_q        <= 10'd0;
            hsw_q         <= 11'd0;
            crc_q         <= 16'hFFFF;
            state_q       <= StAcquire;
            o_pixel_valid <= 1'b0;
            o_x           <= 10'd0;
            o_y           <= 10'd0;
            o_r           <= 2'd0;
            o_g           <= 2'd0;
            o_b           <= 2'd0;
            o_frame_done  <= 1'b0;
            o_frame_crc   <= 16'd0;
            o_h_period    <= 11'd0;
            o_v_lines     <= 10'd0;
            o_error       <= 1'b0;
        end else begin
            pmod_q        <= i_pmod;
            hs_prev_q     <= hs_act;
            hcnt_q        <= hpos;
            vcnt_q        <= vpos;
            hsw_q         <= hsw_d;
            crc_q         <= crc_d;
            state_q       <= state_d;
            o_pixel_valid <= active;
            o_x           <= x_d;
            o_y           <= y_d;
            o_r           <= active ? r_s : 2'd0;
            o_g           <= active ? g_s : 2'd0;
            o_b           <= active ? b_s : 2'd0;
            o_frame_done  <= done_d;
            o_error       <= err_d;
            if (hs_edge) begin
                vs_edge_q  <= vs_act;
                o_h_period <= period;
            end
            if (frame_start) o_v_lines <= lines;
            if (done_d) o_frame_crc <= crc_q;
        end
    end

    assign o_locked = (state_q == StLocked);

endmodule

// File: tb/tb_vga_pmod_receiver.sv
// Scoreboard bench for vga_pmod_receiver on a scaled-down 32x15 geometry so many frames fit.
module tb_vga_pmod_receiver;

    localparam int HA = 16, HF = 4, HS = 8, HB = 4;
    localparam int VA = 8, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int TagNone = 0, TagFs = 1, TagLate = 2, TagWhite = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_pmod = 8'h88;
    logic        o_pixel_valid, o_locked, o_frame_done, o_error;
    logic [9:0]  o_x, o_y, o_v_lines;
    logic [1:0]  o_r, o_g, o_b;
    logic [15:0] o_frame_crc;
    logic [10:0] o_h_period;

    vga_pmod_receiver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .i_pmod(i_pmod),
        .o_pixel_valid(o_pixel_valid), .o_x(o_x), .o_y(o_y),
        .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_locked(o_locked), .o_frame_done(o_frame_done), .o_frame_crc(o_frame_crc),
        .o_h_period(o_h_period), .o_v_lines(o_v_lines), .o_error(o_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [26:0] px;
        int          tag;
        int          frm;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0, n_errors = 0;
    int          n_err = 0, n_done = 0, n_valid = 0;
    int          frm = 0;
    bit          px_chk = 1'b1;
    logic        fs_lock[0:31], fs_done[0:31];
    logic [15:0] fs_crc[0:31], model_crc[0:31];
    int          fs_nerr[0:31], fs_ndone[0:31], fs_nvalid[0:31];
    logic        late_err, late_lock;
    logic [10:0] late_per;
    logic [26:0] white_obs;
    int          base;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [5:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 5; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
            else              r = r << 1;
        end
        return r;
    endfunction

    task automatic observe(input exp_t e);
        if (o_error) n_err++;
        if (o_frame_done) n_done++;
        if (o_pixel_valid) n_valid++;
        if (e.chk) check_eq("pixel", {o_pixel_valid, o_x, o_y, o_r, o_g, o_b}, e.px);
        if (e.tag == TagFs) begin
            fs_lock[e.frm]   = o_locked;
            fs_done[e.frm]   = o_frame_done;
            fs_crc[e.frm]    = o_frame_crc;
            fs_nerr[e.frm]   = n_err;
            fs_ndone[e.frm]  = n_done;
            fs_nvalid[e.frm] = n_valid;
        end else if (e.tag == TagLate) begin
            late_err  = o_error;
            late_lock = o_locked;
            late_per  = o_h_period;
        end else if (e.tag == TagWhite) begin
            white_obs = {o_pixel_valid, o_x, o_y, o_r, o_g, o_b};
        end
    endtask

    // Output for a drive appears two negedges later; the queue holds the in-flight drives.
    task automatic step(input logic [7:0] pm, input exp_t e);
        exp_t o;
        @(negedge clk);
        if (q.size() >= 2) begin
            o = q.pop_front();
            observe(o);
        end
        i_pmod = pm;
        q.push_back(e);
    endtask

    task automatic send_frame(input int long_v, input bit white, input bit blank,
                              input int first, input int last);
        int          idx, len;
        logic [15:0] crc;
        logic [1:0]  r, g, b;
        logic        act, hsl, vsl;
        exp_t        e;
        idx = 0;
        crc = 16'hFFFF;
        if (first == 0) frm++;
        for (int v = 0; v < VT; v++) begin
            len = (v == long_v) ? HT + 1 : HT;
            for (int h = 0; h < len; h++) begin
                r = 2'd0; g = 2'd0; b = 2'd0;
                act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
                if (white && h == HS + HB + 5 && v == VS + VB + 7) begin
                    r = 2'd3; g = 2'd3; b = 2'd3;
                end
                if (blank && h == 10 && v == 7) r = 2'd1;
                hsl = (h < HS) ? 1'b0 : 1'b1;
                vsl = (v < VS) ? 1'b0 : 1'b1;
                e.chk = px_chk;
                e.frm = frm;
                e.tag = TagNone;
                e.px  = act ? {1'b1, 10'(h - HS - HB), 10'(v - VS - VB), r, g, b} : 27'd0;
                if (h == 0 && v == 0) e.tag = TagFs;
                if (long_v >= 0 && h == 0 && v == long_v + 1) e.tag = TagLate;
                if (white && h == HS + HB + 5 && v == VS + VB + 7) e.tag = TagWhite;
                if (act) crc = crc_px(crc, {r, g, b});
                if (idx >= first && idx < last)
                    step({hsl, b[0], g[0], r[0], vsl, b[1], g[1], r[1]}, e);
                idx++;
            end
        end
        model_crc[frm] = crc;
    endtask

    initial begin
        exp_t idle;
        idle.chk = 1'b0; idle.px = 27'd0; idle.tag = TagNone; idle.frm = 0;

        repeat (3) @(negedge clk);
        check_eq("rst_pix", {o_pixel_valid, o_x, o_y, o_r, o_g, o_b}, 64'd0);
        check_eq("rst_ctl", {o_locked, o_frame_done, o_error, o_frame_crc, o_h_period, o_v_lines}, 64'd0);
        rst = 1'b0;

        // Nominal lock-up, then a single white pixel frame.
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        send_frame(-1, 1'b1, 1'b0, 0, 1 << 30);
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        check_eq("f1_lock", fs_lock[1], 1'b0);
        check_eq("f2_lock", fs_lock[2], 1'b1);
        check_eq("f2_done", fs_done[2], 1'b0);
        check_eq("f3_done", fs_done[3], 1'b1);
        check_eq("crc_black", fs_crc[3], model_crc[2]);
        check_eq("crc_white", fs_crc[4], model_crc[3]);
        check_eq("crc_black2", fs_crc[5], model_crc[4]);
        check_eq("crc_differs", fs_crc[4] != fs_crc[3], 1'b1);
        check_eq("valid_count", fs_nvalid[4] - fs_nvalid[3], HA * VA);
        check_eq("white_px", white_obs, {1'b1, 10'd5, 10'd7, 2'd3, 2'd3, 2'd3});
        check_eq("h_period", o_h_period, HT);
        check_eq("v_lines", o_v_lines, VT);
        check_eq("no_err_nominal", fs_nerr[5], 0);

        // One line stretched by a cycle while locked.
        send_frame(7, 1'b0, 1'b0, 0, 1 << 30);
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        check_eq("late_err", late_err, 1'b1);
        check_eq("late_lock", late_lock, 1'b0);
        check_eq("late_period", late_per, HT + 1);
        check_eq("late_err_once", fs_nerr[7] - fs_nerr[6], 1);
        check_eq("relock_f7", fs_lock[7], 1'b0);
        check_eq("relock_f8", fs_lock[8], 1'b1);
        check_eq("relock_done", fs_done[9], 1'b1);
        check_eq("relock_crc", fs_crc[9], model_crc[8]);

        // Hsync disappears: horizontal counter saturation must drop lock.
        base = n_err;
        repeat (2100) step(8'h88, idle);
        check_eq("sat_err", n_err - base, 1);
        check_eq("sat_lock", o_locked, 1'b0);

        // Asynchronous reset in the middle of a locked frame.
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        px_chk = 1'b0;
        send_frame(-1, 1'b0, 1'b0, 0, 200);
        @(posedge clk);
        #2;
        check_eq("pre_rst_lock", o_locked, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("arst_pix", {o_pixel_valid, o_x, o_y, o_r, o_g, o_b}, 64'd0);
        check_eq("arst_ctl", {o_locked, o_frame_done, o_error, o_frame_crc, o_h_period, o_v_lines}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = n_done;
        send_frame(-1, 1'b0, 1'b0, 200, 1 << 30);
        px_chk = 1'b1;
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        check_eq("rst_f13_lock", fs_lock[13], 1'b0);
        check_eq("rst_f14_lock", fs_lock[14], 1'b1);
        check_eq("rst_no_done", fs_ndone[14] - base, 0);
        check_eq("rst_f15_done", fs_done[15], 1'b1);
        check_eq("rst_f15_crc", fs_crc[15], model_crc[14]);

        // Non-zero colour in blanking while locked.
        send_frame(-1, 1'b0, 1'b1, 0, 1 << 30);
        send_frame(-1, 1'b0, 1'b0, 0, 1 << 30);
        check_eq("f16_done", fs_done[16], 1'b1);
`ifdef VGA_RX_BLANK_CHECK_EN
        check_eq("blank_err", fs_nerr[17] - fs_nerr[16], 1);
        check_eq("blank_lock", fs_lock[17], 1'b0);
`else
        check_eq("blank_err", fs_nerr[17] - fs_nerr[16], 0);
        check_eq("blank_lock", fs_lock[17], 1'b1);
        check_eq("blank_done", fs_done[17], 1'b1);
`endif
        repeat (3) step(8'h88, idle);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
